// File: rtl/det_stream_engine.sv
// det_stream_engine: streamed NxN (N = 2..4) determinant by permutation-term
// enumeration. One term is issued per cycle; stage 1 registers the product
// and stage 2 adds or subtracts it into a full-precision accumulator.
module det_stream_engine #(
   parameter int DATA_W    = 6,
   parameter bit SIGNED_IN = 1'b1,
   parameter int OUT_W     = 4*DATA_W+6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2:0]              in_size,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] out_det,
   output logic                    out_err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CALC  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Lexicographic permutations of 0..3 with parity; {neg, p0, p1, p2, p3}.
   // The N=3 and N=2 orderings are the subsets whose trailing digits are fixed.
   function automatic logic [8:0] perm_rom(input logic [4:0] idx);
      logic [8:0] v;
      case (idx)
         5'd0:    v = {1'b0, 2'd0, 2'd1, 2'd2, 2'd3};
         5'd1:    v = {1'b1, 2'd0, 2'd1, 2'd3, 2'd2};
         5'd2:    v = {1'b1, 2'd0, 2'd2, 2'd1, 2'd3};
         5'd3:    v = {1'b0, 2'd0, 2'd2, 2'd3, 2'd1};
         5'd4:    v = {1'b0, 2'd0, 2'd3, 2'd1, 2'd2};
         5'd5:    v = {1'b1, 2'd0, 2'd3, 2'd2, 2'd1};
         5'd6:    v = {1'b1, 2'd1, 2'd0, 2'd2, 2'd3};
         5'd7:    v = {1'b0, 2'd1, 2'd0, 2'd3, 2'd2};
         5'd8:    v = {1'b0, 2'd1, 2'd2, 2'd0, 2'd3};
         5'd9:    v = {1'b1, 2'd1, 2'd2, 2'd3, 2'd0};
         5'd10:   v = {1'b1, 2'd1, 2'd3, 2'd0, 2'd2};
         5'd11:   v = {1'b0, 2'd1, 2'd3, 2'd2, 2'd0};
         5'd12:   v = {1'b0, 2'd2, 2'd0, 2'd1, 2'd3};
         5'd13:   v = {1'b1, 2'd2, 2'd0, 2'd3, 2'd1};
         5'd14:   v = {1'b1, 2'd2, 2'd1, 2'd0, 2'd3};
         5'd15:   v = {1'b0, 2'd2, 2'd1, 2'd3, 2'd0};
         5'd16:   v = {1'b0, 2'd2, 2'd3, 2'd0, 2'd1};
         5'd17:   v = {1'b1, 2'd2, 2'd3, 2'd1, 2'd0};
         5'd18:   v = {1'b1, 2'd3, 2'd0, 2'd1, 2'd2};
         5'd19:   v = {1'b0, 2'd3, 2'd0, 2'd2, 2'd1};
         5'd20:   v = {1'b0, 2'd3, 2'd1, 2'd0, 2'd2};
         5'd21:   v = {1'b1, 2'd3, 2'd1, 2'd2, 2'd0};
         5'd22:   v = {1'b1, 2'd3, 2'd2, 2'd0, 2'd1};
         5'd23:   v = {1'b0, 2'd3, 2'd2, 2'd1, 2'd0};
         default: v = {1'b0, 2'd0, 2'd1, 2'd2, 2'd3};
      endcase
      return v;
   endfunction

   // Widen one element to accumulator precision (sign- or zero-extended).
   function automatic logic signed [OUT_W-1:0] ext_elem(input logic [DATA_W-1:0] d);
      logic signed [OUT_W-1:0] v;
      if (SIGNED_IN) begin
         v = {{(OUT_W-DATA_W){d[DATA_W-1]}}, d};
      end else begin
         v = {{(OUT_W-DATA_W){1'b0}}, d};
      end
      return v;
   endfunction

   state_t                  r_state, w_state_nxt;
   logic [2:0]              r_n;
   logic [3:0]              r_cnt;
   logic [4:0]              r_term;
   logic                    r_drain;
   logic                    r_err;
   logic [DATA_W-1:0]       r_mat [0:15];
   logic signed [OUT_W-1:0] r_prod;
   logic                    r_prod_vld;
   logic                    r_prod_neg;
   logic signed [OUT_W-1:0] r_acc;
   logic                    r_in_ready;
   logic                    r_out_valid;
   logic signed [OUT_W-1:0] r_out_det;
   logic                    r_out_err;

   logic                    w_beat;
   logic                    w_size_ok;
   logic [3:0]              w_last_beat;
   logic [4:0]              w_last_term;
   logic [4:0]              w_rom_idx;
   logic [8:0]              w_rom;
   logic [3:0]              w_idx [0:3];
   logic signed [OUT_W-1:0] w_fac [0:3];
   logic signed [OUT_W-1:0] w_prod;
   logic [3:0]              w_wr_idx;

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_det   = r_out_det;
   assign out_err   = r_out_err;

   assign w_beat    = in_valid && r_in_ready;
   assign w_size_ok = (in_size >= 3'd2) && (in_size <= 3'd4);
   assign w_wr_idx  = (r_state == IDLE) ? 4'd0 : r_cnt;

   // Per-size limits and mapping of the term counter onto the shared ROM.
   always_comb begin
      w_last_beat = 4'd15;
      w_last_term = 5'd23;
      w_rom_idx   = r_term;
      case (r_n)
         3'd2: begin
            w_last_beat = 4'd3;
            w_last_term = 5'd1;
            w_rom_idx   = r_term[0] ? 5'd6 : 5'd0;
         end
         3'd3: begin
            w_last_beat = 4'd8;
            w_last_term = 5'd5;
            case (r_term)
               5'd0:    w_rom_idx = 5'd0;
               5'd1:    w_rom_idx = 5'd2;
               5'd2:    w_rom_idx = 5'd6;
               5'd3:    w_rom_idx = 5'd8;
               5'd4:    w_rom_idx = 5'd12;
               5'd5:    w_rom_idx = 5'd14;
               default: w_rom_idx = 5'd0;
            endcase
         end
         default: begin
            w_last_beat = 4'd15;
            w_last_term = 5'd23;
            w_rom_idx   = r_term;
         end
      endcase
   end

   assign w_rom = perm_rom(w_rom_idx);

   // Gather a[r][p_r] for each used row; unused rows contribute a factor of 1.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         w_idx[r] = 4'(r * int'(r_n)) + 4'(w_rom[7-2*r -: 2]);
         if (r < int'(r_n)) begin
            w_fac[r] = ext_elem(r_mat[w_idx[r]]);
         end else begin
            w_fac[r] = OUT_W'(1'b1);
         end
      end
      w_prod = w_fac[0] * w_fac[1] * w_fac[2] * w_fac[3];
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_beat) begin
               w_state_nxt = w_size_ok ? LOAD : DONE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LOAD: begin
            if (w_beat && (r_cnt == w_last_beat)) begin
               w_state_nxt = CALC;
            end else begin
               w_state_nxt = LOAD;
            end
         end
         CALC: begin
            if (r_term == w_last_term) begin
               w_state_nxt = DRAIN;
            end else begin
               w_state_nxt = CALC;
            end
         end
         DRAIN: begin
            if (r_drain) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = DRAIN;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register and handshake; ready stays low for the result-pulse cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= ((w_state_nxt == IDLE) || (w_state_nxt == LOAD)) && (r_state != DONE);
      end
   end

   // Frame bookkeeping: size, beat/term counters, drain timer, error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_n     <= 3'd0;
         r_cnt   <= 4'd0;
         r_term  <= 5'd0;
         r_drain <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_beat) begin
                  r_n   <= in_size;
                  r_cnt <= 4'd1;
                  r_err <= !w_size_ok;
               end
            end
            LOAD: begin
               if (w_beat) begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            CALC:  r_term  <= r_term + 5'd1;
            DRAIN: r_drain <= 1'b1;
            DONE: begin
               r_cnt   <= 4'd0;
               r_term  <= 5'd0;
               r_drain <= 1'b0;
               r_err   <= 1'b0;
            end
            default: begin
               r_cnt   <= 4'd0;
               r_term  <= 5'd0;
               r_drain <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   // Element storage; contents are only meaningful within a frame.
   always_ff @(posedge clk) begin
      if (w_beat) begin
         r_mat[w_wr_idx] <= in_data;
      end
   end

   // Stage 1 registers the term product, stage 2 accumulates it with its sign.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod     <= '0;
         r_prod_vld <= 1'b0;
         r_prod_neg <= 1'b0;
         r_acc      <= '0;
      end else begin
         r_prod     <= w_prod;
         r_prod_vld <= (r_state == CALC);
         r_prod_neg <= w_rom[8];
         if (r_state == DONE) begin
            r_acc <= '0;
         end else if (r_prod_vld) begin
            r_acc <= r_prod_neg ? (r_acc - r_prod) : (r_acc + r_prod);
         end
      end
   end

   // Result registers: one-cycle pulse, determinant forced to 0 otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_det   <= '0;
         r_out_err   <= 1'b0;
      end else begin
         r_out_valid <= (r_state == DONE);
         r_out_det   <= ((r_state == DONE) && !r_err) ? r_acc : '0;
         r_out_err   <= (r_state == DONE) && r_err;
      end
   end

endmodule

// File: tb/tb_det_stream_engine.sv
// Directed bench for det_stream_engine: a signed instance and an unsigned
// instance share stimulus; sel chooses which one the beats go to.
module tb_det_stream_engine;
   localparam int DW = 6;
   localparam int OW = 4*DW+6;

   logic clk = 1'b0;
   logic rst_n;
   logic sel;
   logic s_valid;
   logic [2:0] in_size;
   logic [DW-1:0] in_data;

   logic a_ready, a_vo, a_err;
   logic signed [OW-1:0] a_det;
   logic b_ready, b_vo, b_err;
   logic signed [OW-1:0] b_det;
   logic m_ready, m_vo, m_err;
   logic signed [OW-1:0] m_det;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] mat [16];

   always #5 clk = ~clk;

   det_stream_engine #(.DATA_W(DW), .SIGNED_IN(1'b1), .OUT_W(OW)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid && !sel), .in_ready(a_ready),
      .in_size(in_size), .in_data(in_data), .out_valid(a_vo), .out_det(a_det), .out_err(a_err));

   det_stream_engine #(.DATA_W(DW), .SIGNED_IN(1'b0), .OUT_W(OW)) u_dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid && sel), .in_ready(b_ready),
      .in_size(in_size), .in_data(in_data), .out_valid(b_vo), .out_det(b_det), .out_err(b_err));

   assign m_ready = sel ? b_ready : a_ready;
   assign m_vo    = sel ? b_vo    : a_vo;
   assign m_err   = sel ? b_err   : a_err;
   assign m_det   = sel ? b_det   : a_det;

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one beat once the engine is ready; returns #1 after the accepting edge.
   task automatic send(input logic [2:0] sz, input logic [DW-1:0] d);
      int w = 0;
      while (!m_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      s_valid = 1'b1; in_size = sz; in_data = d;
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   // Stream an n x n frame from mat; later beats carry a bogus in_size.
   task automatic send_frame(input int n, input bit gaps);
      for (int i = 0; i < n*n; i++) begin
         if (gaps && i > 0) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk); #1;
            end
         end
         send((i == 0) ? 3'(n) : 3'd7, mat[i]);
      end
   endtask

   // Wait for the result pulse (bounded) and check latency, value, ready and pulse width.
   task automatic wait_res(input bit junk, input int exp_lat, input logic signed [63:0] exp_det,
                           input logic exp_err, input string tag);
      int n = 0;
      logic rdy_hi = 1'b0;
      if (junk) begin
         s_valid = 1'b1; in_size = 3'd2; in_data = DW'($urandom);
      end
      while (!m_vo && n < 60) begin
         if (m_ready) rdy_hi = 1'b1;
         @(posedge clk); #1; n++;
         if (junk) in_data = DW'($urandom);
      end
      if (m_ready) rdy_hi = 1'b1;
      s_valid = 1'b0;
      check({tag, "_lat"}, 64'(n), 64'(exp_lat));
      check({tag, "_det"}, m_det, exp_det);
      check({tag, "_err"}, 64'(m_err), 64'(exp_err));
      check({tag, "_rdy_low"}, 64'(rdy_hi), 64'sd0);
      @(posedge clk); #1;
      check({tag, "_pulse_off"}, 64'(m_vo), 64'sd0);
      check({tag, "_det_off"}, m_det, 64'sd0);
   endtask

   initial begin
      logic seen;
      rst_n = 1'b0; sel = 1'b0; s_valid = 1'b0; in_size = 3'd0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(m_ready), 64'sd1);
      check("rst_valid", 64'(m_vo), 64'sd0);
      check("rst_det", m_det, 64'sd0);
      check("rst_err", 64'(m_err), 64'sd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // N=4 identity, continuous beats
      mat = '{0: 6'd1, 5: 6'd1, 10: 6'd1, 15: 6'd1, default: 6'd0};
      send_frame(4, 1'b0);
      wait_res(1'b0, 27, 64'sd1, 1'b0, "id4");

      // N=2 then N=3 back-to-back, junk beats during busy windows
      mat = '{0: 6'd3, 1: 6'd4, 2: 6'd5, 3: 6'd6, default: 6'd0};
      send_frame(2, 1'b0);
      wait_res(1'b1, 5, -64'sd2, 1'b0, "n2");
      mat = '{0: 6'd2, 1: 6'd0, 2: 6'd1, 3: 6'd1, 4: 6'd3, 5: 6'd2, 6: 6'd1, 7: 6'd1, 8: 6'd2, default: 6'd0};
      send_frame(3, 1'b0);
      wait_res(1'b1, 9, 64'sd6, 1'b0, "n3");

      // Signed diag(-32) with random gaps
      mat = '{0: 6'h20, 5: 6'h20, 10: 6'h20, 15: 6'h20, default: 6'd0};
      send_frame(4, 1'b1);
      wait_res(1'b0, 27, 64'sd1048576, 1'b0, "diag_neg");

      // Unsigned instance, 63 treated as +63
      sel = 1'b1;
      mat = '{0: 6'd63, 3: 6'd63, default: 6'd0};
      send_frame(2, 1'b0);
      wait_res(1'b0, 5, 64'sd3969, 1'b0, "unsigned");
      sel = 1'b0;

      // Illegal size, then a fresh frame
      send(3'd5, 6'd9);
      wait_res(1'b0, 1, 64'sd0, 1'b1, "bad_size");
      mat = '{0: 6'd1, 1: 6'd2, 2: 6'd3, 3: 6'd4, default: 6'd0};
      send_frame(2, 1'b0);
      wait_res(1'b0, 5, -64'sd2, 1'b0, "after_bad");

      // Reset during CALC of an N=4 frame
      mat = '{0: 6'd2, 5: 6'd2, 10: 6'd2, 15: 6'd2, default: 6'd0};
      send_frame(4, 1'b0);
      repeat (6) @(posedge clk);
      #2;
      check("calc_ready_low", 64'(m_ready), 64'sd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 64'(m_ready), 64'sd1);
      check("mid_rst_valid", 64'(m_vo), 64'sd0);
      check("mid_rst_det", m_det, 64'sd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (35) begin
         @(posedge clk); #1;
         if (m_vo) seen = 1'b1;
      end
      check("no_stale_pulse", 64'(seen), 64'sd0);
      mat = '{0: 6'd1, 1: 6'd1, 2: 6'd1, 3: 6'd1, 4: 6'd1, 5: 6'd1, 6: 6'd1, 7: 6'd1, 8: 6'd1, default: 6'd0};
      send_frame(3, 1'b0);
      wait_res(1'b0, 9, 64'sd0, 1'b0, "ones3");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
